// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the 5-stage MIPS32 core.
//
// Merges the IF/ID/EX stall requests into one per-stage hold vector,
// counts out multi-cycle EX operations (mult/div/madd), sequences the
// exception flush/redirect and keeps a saturating stall-cycle counter.
//
// Ports:
//   clk                 clock
//   rst                 asynchronous reset, active low
//   stallreq_if_i       fetch not ready
//   stallreq_id_i       load-use hazard in ID
//   ex_multi_start_i    EX starts a multi-cycle op (1-cycle pulse)
//   ex_multi_cycles_i   length N of that op (N=0 treated as 1)
//   exc_valid_i         MEM-stage exception commit (1-cycle pulse)
//   exc_pc_i            exception handler address
//   stall_o             per-stage hold: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   ex_multi_done_o     EX result valid / EX released (1-cycle pulse)
//   flush_o             clear all pipeline registers (1-cycle pulse)
//   new_pc_o            redirect PC, valid while flush_o=1
//   busy_o              sequencer not in RUN
//   proto_err_o         sticky: start seen while MULTI or FLUSH
//   stall_cnt_o         saturating count of cycles with stall_o[0]=1
module pipe_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if_i,
    input  logic              stallreq_id_i,
    input  logic              ex_multi_start_i,
    input  logic [CNT_W-1:0]  ex_multi_cycles_i,
    input  logic              exc_valid_i,
    input  logic [31:0]       exc_pc_i,
    output logic [5:0]        stall_o,
    output logic              ex_multi_done_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              busy_o,
    output logic              proto_err_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {S_RUN, S_MULTI, S_FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_flush;
    logic [31:0]        r_new_pc;
    logic               r_proto_err;
    logic [PERF_W-1:0]  r_stall_cnt;

    logic               w_start_ok;
    logic               w_ex_hold;
    logic               w_done;
    logic [5:0]         w_stall;

    // A start is only accepted from RUN and loses to a same-cycle exception.
    assign w_start_ok = (r_state == S_RUN) && ex_multi_start_i && !exc_valid_i;
    // EX is held on the start cycle and on every MULTI cycle until count hits 1.
    assign w_ex_hold  = w_start_ok || ((r_state == S_MULTI) && (r_count > CNT_ONE));
    // An exception on the would-be done cycle aborts the op with no pulse.
    assign w_done     = (r_state == S_MULTI) && (r_count == CNT_ONE) && !exc_valid_i;

    always_comb begin
        w_stall = 6'b000000;
        if (exc_valid_i)            w_stall = 6'b111111;
        else if (r_state == S_FLUSH) w_stall = 6'b000000;
        else if (w_ex_hold)         w_stall = 6'b001111;
        else if (stallreq_id_i)     w_stall = 6'b000111;
        else if (stallreq_if_i)     w_stall = 6'b000011;
    end

    // Combinational outputs are forced low while reset is asserted so that
    // every output reads zero immediately, independent of the request inputs.
    assign stall_o         = rst ? w_stall : 6'b000000;
    assign ex_multi_done_o = rst & w_done;
    assign flush_o         = r_flush;
    assign new_pc_o        = r_new_pc;
    assign busy_o          = (r_state != S_RUN);
    assign proto_err_o     = r_proto_err;
    assign stall_cnt_o     = r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_count     <= '0;
            r_flush     <= 1'b0;
            r_new_pc    <= '0;
            r_proto_err <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall[0] && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);

            if (exc_valid_i) begin
                r_state  <= S_FLUSH;
                r_flush  <= 1'b1;
                r_new_pc <= exc_pc_i;
                r_count  <= '0;
            end else begin
                r_flush <= 1'b0;
                if (ex_multi_start_i && (r_state != S_RUN))
                    r_proto_err <= 1'b1;
                case (r_state)
                    S_RUN: begin
                        if (ex_multi_start_i) begin
                            r_state <= S_MULTI;
                            r_count <= (ex_multi_cycles_i == '0) ? CNT_ONE : ex_multi_cycles_i;
                        end
                    end
                    S_MULTI: begin
                        if (r_count > CNT_ONE) r_count <= r_count - CNT_ONE;
                        else                   r_state <= S_RUN;
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS32 core: PC, IF, ID, EX, MEM, WB.
- Merges stall requests from IF, ID and EX into one 6-bit stall vector.
- Owns the cycle counter for multi-cycle EX operations (mult/div/madd).
- Sequences the exception flush and redirect, and keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 6, width of the multi-cycle operation length field (max 63 cycles).
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- stallreq_if_i  input  1  fetch not ready (bus wait).
- stallreq_id_i  input  1  load-use hazard detected in ID.
- ex_multi_start_i  input  1  EX begins a multi-cycle op, one-cycle pulse.
- ex_multi_cycles_i  input  CNT_W  length N of that op.
- exc_valid_i  input  1  MEM-stage exception commit, one-cycle pulse.
- exc_pc_i  input  32  handler address.
- stall_o  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold that stage.
- ex_multi_done_o  output  1  one-cycle pulse, EX result valid, EX released.
- flush_o  output  1  one-cycle pulse, clear all pipeline registers.
- new_pc_o  output  32  redirect PC, valid while flush_o=1.
- busy_o  output  1  state is not RUN.
- proto_err_o  output  1  sticky protocol error.
- stall_cnt_o  output  PERF_W  cycles with stall_o[0]=1, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Reset values (rst=0): state RUN, count=0, stall_o=0, ex_multi_done_o=0, flush_o=0, new_pc_o=0, proto_err_o=0, stall_cnt_o=0. All of these apply immediately, including mid-MULTI or mid-FLUSH.
- State register: RUN, MULTI, FLUSH. stall_o and ex_multi_done_o are combinational from state and inputs; flush_o and new_pc_o are registered.
- Priority of stall_o, highest first:
  - exc_valid_i=1 in any state: 6'b111111.
  - state FLUSH: 6'b000000.
  - EX hold (see MULTI): 6'b001111.
  - stallreq_id_i: 6'b000111.
  - stallreq_if_i: 6'b000011.
  - otherwise 6'b000000.
- Multi-cycle op sequencing:
  - In RUN, when ex_multi_start_i=1 and exc_valid_i=0: EX hold applies this cycle; count<=max(N,1); next state MULTI.
  - In MULTI:
    - count>1: EX hold; count decrements.
    - count==1: ex_multi_done_o=1; no EX hold (lower requests still apply); next state RUN.
  - Net effect: EX is held for exactly N cycles, counting the start cycle; done arrives on cycle N+1 after start. N=0 behaves as N=1.
  - ex_multi_start_i while in MULTI or FLUSH: ignored, and proto_err_o<=1.
- Exception flush:
  - exc_valid_i=1 at cycle t, any state: freeze all stages at t; any MULTI op is aborted with no done pulse; next state FLUSH; new_pc_o<=exc_pc_i.
  - Cycle t+1: flush_o=1, stall_o=0.
  - Exit from FLUSH:
    - exc_valid_i=0 at t+1: back to RUN at t+2, flush_o=0.
    - exc_valid_i=1 at t+1: stay FLUSH; flush_o stays 1 at t+2 with the new exc_pc_i.
  - ex_multi_start_i in the same cycle as exc_valid_i: flush wins, start is dropped, no proto_err.
  - new_pc_o holds its last value outside a flush.
- Performance counter: stall_cnt_o increments on each clk edge where stall_o[0]=1 and saturates at all-ones.
- busy_o=1 in MULTI or FLUSH.

Test Plan:
- Reset mid-MULTI: start N=10, assert rst=0 at cycle 4 → all outputs 0 asynchronously, state RUN after release, no done pulse.
- Multi-cycle op: start with N=5, no other requests → stall_o=001111 for 5 cycles, ex_multi_done_o=1 on cycle 6 with stall_o=0, stall_cnt_o=5.
- Priority mix: stallreq_if_i=1 and stallreq_id_i=1 together → 000111; in MULTI with stallreq_id_i=1 → 001111; on the done cycle with stallreq_id_i=1 → 000111.
- Exception aborts MULTI: start N=20, exc_valid_i=1 with exc_pc_i=32'hBFC00380 at cycle 3 → that cycle stall_o=111111; next cycle flush_o=1, new_pc_o=32'hBFC00380; never a done pulse; RUN afterwards.
- Back-to-back exceptions: exc_valid_i on two consecutive cycles with exc_pc_i=32'h80000180, then 32'h80000200 → flush_o high for two cycles, new_pc_o shows 32'h80000180, then 32'h80000200.
- Protocol error and N=0: second start during MULTI → proto_err_o=1 and stays set until reset; start with N=0 → one stall cycle, done on the following cycle.
